// File: rtl/instr_mem_prog_if.sv
// instr_mem_prog_if
//   Bundles the program-load stream and the instruction-fetch port of the
//   loadable instruction memory.
//   master : the loader/core side (drives prog_*, fetch_en, Instruction_addr)
//   slave  : the memory side (drives prog_ready, prog_count, prog_done,
//            Instruction_Data, instr_valid, fault_misalign, fault_range)
//   Parameters must match those of the instr_mem_prog instance it connects to.
interface instr_mem_prog_if #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_SIZE = 32
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  // program load stream
  logic                 prog_start;
  logic                 prog_valid;
  logic                 prog_ready;
  logic [MEM_WIDTH-1:0] prog_data;
  logic                 prog_last;
  logic [IDX_W:0]       prog_count;
  logic                 prog_done;

  // instruction fetch
  logic                 fetch_en;
  logic [ADDR_SIZE-1:0] Instruction_addr;
  logic [MEM_WIDTH-1:0] Instruction_Data;
  logic                 instr_valid;
  logic                 fault_misalign;
  logic                 fault_range;

  modport master (
    output prog_start, prog_valid, prog_data, prog_last,
    output fetch_en, Instruction_addr,
    input  prog_ready, prog_count, prog_done,
    input  Instruction_Data, instr_valid, fault_misalign, fault_range
  );

  modport slave (
    input  prog_start, prog_valid, prog_data, prog_last,
    input  fetch_en, Instruction_addr,
    output prog_ready, prog_count, prog_done,
    output Instruction_Data, instr_valid, fault_misalign, fault_range
  );
endinterface

// File: rtl/instr_mem_prog.sv
// instr_mem_prog
//   Loadable instruction memory for the single-cycle MIPS32 core.
//   A program is streamed in word by word from index 0 (valid/ready), after
//   which the fetch port returns registered instructions with one cycle of
//   latency and flags misaligned or out-of-range addresses.
//   Controller: IDLE -> LOAD (prog_start) -> RUN (last beat or array full);
//   prog_start in RUN reloads. Fetches are serviced only in RUN.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (array contents are not reset)
//   bus   : instr_mem_prog_if.slave
//     prog_start/prog_valid/prog_data/prog_last in, prog_ready/prog_count/
//     prog_done out; fetch_en/Instruction_addr in, Instruction_Data/
//     instr_valid/fault_misalign/fault_range out
module instr_mem_prog #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_SIZE = 32
) (
  input logic            clk,
  input logic            rst_n,
  instr_mem_prog_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W:0]   count;
  logic             ready;
  logic             done;
  logic             beat;
  logic             full;
  logic             load_req;

  logic [ADDR_SIZE-1:0] word_idx;
  logic                 misalign;
  logic                 out_range;

  logic [MEM_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 flt_mis;
  logic                 flt_rng;

  // ---------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Controller: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.prog_start) state_nxt = LOAD;
      // prog_start is ignored while loading
      LOAD: if (beat && (bus.prog_last || full)) state_nxt = RUN;
      RUN:  if (bus.prog_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Controller: Moore outputs
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      LOAD:    ready = 1'b1;
      RUN:     done  = 1'b1;
      default: ;
    endcase
  end

  assign bus.prog_ready = ready;
  assign bus.prog_done  = done;

  // ---------------------------------------------------------------------
  // Program load path
  // ---------------------------------------------------------------------
  assign beat     = ready && bus.prog_valid;
  // Leaving LOAD on the full beat stops writes before wr_ptr could wrap.
  assign full     = (wr_ptr == IDX_W'(MEM_DEPTH - 1));
  assign load_req = bus.prog_start && (state != LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (load_req) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (beat) begin
      wr_ptr <= wr_ptr + IDX_W'(1);
      count  <= count + (IDX_W + 1)'(1);
    end
  end

  assign bus.prog_count = count;

  // Array is deliberately not reset so an image survives rst_n.
  always_ff @(posedge clk) begin
    if (beat) mem[wr_ptr] <= bus.prog_data;
  end

  // ---------------------------------------------------------------------
  // Fetch path
  // ---------------------------------------------------------------------
  assign word_idx  = bus.Instruction_addr >> 2;
  assign misalign  = |bus.Instruction_addr[1:0];
  assign out_range = (word_idx >= ADDR_SIZE'(MEM_DEPTH));

  // Writes occur only in LOAD and reads only in RUN, so no bypass is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      flt_mis  <= 1'b0;
      flt_rng  <= 1'b0;
    end else if (bus.fetch_en) begin
      if (state != RUN) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
        flt_mis  <= 1'b0;
        flt_rng  <= 1'b0;
      end else if (misalign || out_range) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
        flt_mis  <= misalign;
        flt_rng  <= out_range;
      end else begin
        rd_data  <= mem[word_idx[IDX_W-1:0]];
        rd_valid <= 1'b1;
        flt_mis  <= 1'b0;
        flt_rng  <= 1'b0;
      end
    end else begin
      // data and fault flags hold; only the valid strobe drops
      rd_valid <= 1'b0;
    end
  end

  assign bus.Instruction_Data = rd_data;
  assign bus.instr_valid      = rd_valid;
  assign bus.fault_misalign   = flt_mis;
  assign bus.fault_range      = flt_rng;

endmodule

// File: tb/tb_instr_mem_prog.sv
// tb_instr_mem_prog
//   Directed bench for instr_mem_prog with MEM_DEPTH = 8. Fetch expectations
//   come from a bench-side model of the array and are queued when a fetch is
//   driven, then popped and compared when the registered result appears.
module tb_instr_mem_prog;
  localparam int MW = 32;
  localparam int MD = 8;
  localparam int AS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_prog_if #(.MEM_WIDTH(MW), .MEM_DEPTH(MD), .ADDR_SIZE(AS)) bus ();

  instr_mem_prog #(.MEM_WIDTH(MW), .MEM_DEPTH(MD), .ADDR_SIZE(AS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        valid;
    logic        fm;
    logic        fr;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [MD];
  int          mcnt    = 0;
  logic        exp_run = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(bus.prog_ready), 32'd0);
    check({tag, "_done"},  32'(bus.prog_done), 32'd0);
    check({tag, "_count"}, 32'(bus.prog_count), 32'd0);
    check({tag, "_data"},  bus.Instruction_Data, 32'd0);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_fm"},    32'(bus.fault_misalign), 32'd0);
    check({tag, "_fr"},    32'(bus.fault_range), 32'd0);
  endtask

  // Drive one fetch at a negedge, compare the result at the following negedge.
  task automatic fetch(input string tag, input logic [31:0] addr);
    exp_t        e;
    exp_t        got;
    logic [31:0] idx;
    idx     = addr >> 2;
    e.tag   = tag;
    e.data  = '0;
    e.valid = 1'b0;
    e.fm    = 1'b0;
    e.fr    = 1'b0;
    if (exp_run) begin
      if (addr[1:0] != 2'b00 || idx >= MD) begin
        e.fm = (addr[1:0] != 2'b00);
        e.fr = (idx >= MD);
      end else begin
        e.data  = model[idx[2:0]];
        e.valid = 1'b1;
      end
    end
    bus.fetch_en         = 1'b1;
    bus.Instruction_addr = addr;
    sb.push_back(e);
    @(negedge clk);
    bus.fetch_en = 1'b0;
    got = sb.pop_front();
    check({got.tag, "_data"},  bus.Instruction_Data, got.data);
    check({got.tag, "_valid"}, 32'(bus.instr_valid), 32'(got.valid));
    check({got.tag, "_fm"},    32'(bus.fault_misalign), 32'(got.fm));
    check({got.tag, "_fr"},    32'(bus.fault_range), 32'(got.fr));
  endtask

  task automatic start_load(input string tag);
    bus.prog_start = 1'b1;
    @(negedge clk);
    bus.prog_start = 1'b0;
    exp_run = 1'b0;
    mcnt    = 0;
    check({tag, "_ready"}, 32'(bus.prog_ready), 32'd1);
    check({tag, "_done"},  32'(bus.prog_done), 32'd0);
    check({tag, "_count"}, 32'(bus.prog_count), 32'd0);
  endtask

  // One accepted beat; the model takes the word only while space remains.
  task automatic send_beat(input logic [31:0] d, input logic last);
    bus.prog_valid = 1'b1;
    bus.prog_data  = d;
    bus.prog_last  = last;
    @(negedge clk);
    bus.prog_valid = 1'b0;
    bus.prog_last  = 1'b0;
    if (mcnt < MD) begin
      model[mcnt] = d;
      mcnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.prog_start       = 1'b0;
    bus.prog_valid       = 1'b0;
    bus.prog_data        = '0;
    bus.prog_last        = 1'b0;
    bus.fetch_en         = 1'b0;
    bus.Instruction_addr = '0;

    // reset state
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    fetch("idle_fetch", 32'h0);

    // basic load of three words
    start_load("ld1");
    send_beat(32'h01098820, 1'b0);
    check("ld1_cnt1", 32'(bus.prog_count), 32'd1);
    send_beat(32'hAC110004, 1'b0);
    send_beat(32'h8C0A0004, 1'b1);
    exp_run = 1'b1;
    check("ld1_cnt3", 32'(bus.prog_count), 32'd3);
    check("ld1_done", 32'(bus.prog_done), 32'd1);
    check("ld1_rdy0", 32'(bus.prog_ready), 32'd0);

    fetch("f_08", 32'h8);
    fetch("f_00", 32'h0);
    fetch("f_04", 32'h4);
    // fetch_en low: data holds, valid drops
    @(negedge clk);
    check("hold_data",  bus.Instruction_Data, 32'hAC110004);
    check("hold_valid", 32'(bus.instr_valid), 32'd0);

    fetch("f_mis", 32'h6);
    @(negedge clk);
    check("hold_fm", 32'(bus.fault_misalign), 32'd1);
    fetch("f_rng",  32'h20);
    fetch("f_both", 32'h22);

    // full load: 10 words offered, 8 accepted
    start_load("ld2");
    for (int i = 0; i < 10; i++) begin
      send_beat(32'h1000_0000 + 32'(i), 1'b0);
      check($sformatf("ld2_rdy%0d", i), 32'(bus.prog_ready), (i < MD - 1) ? 32'd1 : 32'd0);
      check($sformatf("ld2_cnt%0d", i), 32'(bus.prog_count), (i < MD) ? 32'(i + 1) : 32'(MD));
    end
    exp_run = 1'b1;
    check("ld2_done", 32'(bus.prog_done), 32'd1);
    fetch("f_1c", 32'h1C);
    fetch("f_00b", 32'h0);

    // reload with back-pressure
    start_load("ld3");
    fetch("f_in_load", 32'h0);
    check("ld3_gap1", 32'(bus.prog_count), 32'd0);
    @(negedge clk);
    check("ld3_gap2", 32'(bus.prog_count), 32'd0);
    send_beat(32'hDEADBEEF, 1'b1);
    exp_run = 1'b1;
    check("ld3_cnt", 32'(bus.prog_count), 32'd1);
    check("ld3_done", 32'(bus.prog_done), 32'd1);
    fetch("f_dead", 32'h0);

    // reset in the middle of a load
    start_load("ld4");
    send_beat(32'hA000_0000, 1'b0);
    send_beat(32'hA000_0001, 1'b0);
    check("ld4_cnt2", 32'(bus.prog_count), 32'd2);
    check("ld4_data_held", bus.Instruction_Data, 32'hDEADBEEF);
    bus.prog_valid = 1'b1;
    bus.prog_data  = 32'hA000_0002;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    bus.prog_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    exp_run = 1'b0;
    fetch("f_after_rst", 32'h0);
    check("after_rst_cnt", 32'(bus.prog_count), 32'd0);
    check("after_rst_rdy", 32'(bus.prog_ready), 32'd0);

    start_load("ld5");
    send_beat(32'h12345678, 1'b1);
    exp_run = 1'b1;
    fetch("f_new", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
